// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//   Shares one single-port synchronous block RAM between the CPU instruction
//   port and data port. Data accesses win by default; a saturating starvation
//   counter forces an instruction grant after STARVE_LIMIT consecutive lost
//   cycles. A read-tag pipeline, matched to the RAM read latency, steers each
//   returning word to the port that issued it.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   inst_req/addr            instruction fetch request (held until granted)
//   inst_gnt                 fetch accepted this cycle (same-cycle grant)
//   inst_rvalid/rdata        fetched word, RD_LATENCY cycles after grant
//   data_req/addr/wdata/we   load/store request (we == 0 means load)
//   data_gnt                 load/store accepted this cycle
//   data_rvalid/rdata        load word, RD_LATENCY cycles after grant
//   mem_en/we/addr/wdata     RAM command, driven by the granted port
//   mem_rdata                RAM read data, RD_LATENCY cycles after a read
module cpu_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_we,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TAIL  = RD_LATENCY - 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic valid;
        logic is_data;
    } rd_tag_t;

    logic [CNT_W-1:0] r_starve_cnt;
    rd_tag_t          r_tag [RD_LATENCY];

    logic             w_inst_gnt;
    logic             w_data_gnt;
    rd_tag_t          w_tag_in;
    rd_tag_t          w_tag_tail;
    logic             w_unused_addr_lsbs;

    // Byte offsets are meaningless to a word-wide RAM.
    assign w_unused_addr_lsbs = ^{inst_addr[1:0], data_addr[1:0]};

    // Grant decision; requests are ignored while reset is held.
    always_comb begin
        w_inst_gnt = 1'b0;
        w_data_gnt = 1'b0;
        if (aresetn) begin
            if (data_req && !(inst_req && (r_starve_cnt == LIMIT))) begin
                w_data_gnt = 1'b1;
            end else if (inst_req) begin
                w_inst_gnt = 1'b1;
            end
        end
    end

    assign inst_gnt = w_inst_gnt;
    assign data_gnt = w_data_gnt;

    // RAM command mux; all-zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (w_data_gnt) begin
            mem_en    = 1'b1;
            mem_we    = data_we;
            mem_addr  = data_addr[ADDR_W-1:2];
            mem_wdata = data_wdata;
        end else if (w_inst_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = inst_addr[ADDR_W-1:2];
        end
    end

    // Starvation counter: counts consecutive cycles a pending fetch loses.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_starve_cnt <= '0;
        end else if (!inst_req || w_inst_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // Tag for the access issued this cycle; writes and idles carry no response.
    always_comb begin
        w_tag_in = '0;
        if (w_inst_gnt) begin
            w_tag_in = '{valid: 1'b1, is_data: 1'b0};
        end else if (w_data_gnt && (data_we == 4'b0000)) begin
            w_tag_in = '{valid: 1'b1, is_data: 1'b1};
        end
    end

    // Tag shift register aligned with the RAM read latency.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_tag_tail = r_tag[TAIL];

    // Response steering; reset forces everything quiet.
    assign inst_rvalid = aresetn && w_tag_tail.valid && !w_tag_tail.is_data;
    assign data_rvalid = aresetn && w_tag_tail.valid &&  w_tag_tail.is_data;
    assign inst_rdata  = inst_rvalid ? mem_rdata : 32'h0;
    assign data_rdata  = data_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: three instances (RD_LATENCY 1, 2, 3)
// share one set of request inputs; each has its own RAM read-data model.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_we;

    logic        ig_1, iv_1, dg_1, dv_1, men_1;
    logic        ig_2, iv_2, dg_2, dv_2, men_2;
    logic        ig_3, iv_3, dg_3, dv_3, men_3;
    logic [31:0] ir_1, dr_1, mwd_1, ir_2, dr_2, mwd_2, ir_3, dr_3, mwd_3;
    logic [3:0]  mwe_1, mwe_2, mwe_3;
    logic [29:0] maddr_1, maddr_2, maddr_3;
    logic [31:0] rd1;
    logic [31:0] rd2 [2];
    logic [31:0] rd3 [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // RAM contents: a fixed function of the word address.
    function automatic logic [31:0] mw(input logic [29:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Read data returns RD_LATENCY cycles after a read; junk otherwise.
    always @(posedge clk) begin
        rd1    <= (men_1 && mwe_1 == 4'h0) ? mw(maddr_1) : 32'hDEAD_BEEF;
        rd2[0] <= (men_2 && mwe_2 == 4'h0) ? mw(maddr_2) : 32'hDEAD_BEEF;
        rd2[1] <= rd2[0];
        rd3[0] <= (men_3 && mwe_3 == 4'h0) ? mw(maddr_3) : 32'hDEAD_BEEF;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    cpu_mem_arbiter #(.ADDR_W(32), .RD_LATENCY(1), .STARVE_LIMIT(4)) u1 (
        .aclk(clk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(ig_1),
        .inst_rvalid(iv_1), .inst_rdata(ir_1),
        .data_req(data_req), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_we(data_we), .data_gnt(dg_1), .data_rvalid(dv_1), .data_rdata(dr_1),
        .mem_en(men_1), .mem_we(mwe_1), .mem_addr(maddr_1), .mem_wdata(mwd_1),
        .mem_rdata(rd1));

    cpu_mem_arbiter #(.ADDR_W(32), .RD_LATENCY(2), .STARVE_LIMIT(4)) u2 (
        .aclk(clk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(ig_2),
        .inst_rvalid(iv_2), .inst_rdata(ir_2),
        .data_req(data_req), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_we(data_we), .data_gnt(dg_2), .data_rvalid(dv_2), .data_rdata(dr_2),
        .mem_en(men_2), .mem_we(mwe_2), .mem_addr(maddr_2), .mem_wdata(mwd_2),
        .mem_rdata(rd2[1]));

    cpu_mem_arbiter #(.ADDR_W(32), .RD_LATENCY(3), .STARVE_LIMIT(4)) u3 (
        .aclk(clk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(ig_3),
        .inst_rvalid(iv_3), .inst_rdata(ir_3),
        .data_req(data_req), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_we(data_we), .data_gnt(dg_3), .data_rvalid(dv_3), .data_rdata(dr_3),
        .mem_en(men_3), .mem_we(mwe_3), .mem_addr(maddr_3), .mem_wdata(mwd_3),
        .mem_rdata(rd3[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one cycle, drive this cycle's inputs, settle before sampling.
    task automatic cyc(input logic rn, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da, input logic [3:0] we,
                       input logic [31:0] wd);
        @(posedge clk);
        #1;
        aresetn    = rn;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_addr  = da;
        data_we    = we;
        data_wdata = wd;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    logic exp_i;
    logic prev_i;

    initial begin
        aresetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
        data_addr = '0; data_we = '0; data_wdata = '0;

        // Reset held with requests asserted: everything reads 0.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
            check("rst_ignt",  32'(ig_1), 32'h0);
            check("rst_dgnt",  32'(dg_1), 32'h0);
            check("rst_men",   32'(men_1), 32'h0);
            check("rst_mwe",   32'(mwe_1), 32'h0);
            check("rst_maddr", 32'(maddr_1), 32'h0);
            check("rst_mwd",   mwd_1, 32'h0);
            check("rst_rv",    32'({iv_1, dv_1, iv_3, dv_3}), 32'h0);
            check("rst_rd",    ir_1 | dr_1 | ir_3 | dr_3, 32'h0);
        end
        idle(2);

        // Single fetch, latency 1.
        cyc(1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 32'h0);
        check("fetch_gnt",   32'(ig_1), 32'h1);
        check("fetch_dgnt",  32'(dg_1), 32'h0);
        check("fetch_men",   32'(men_1), 32'h1);
        check("fetch_maddr", 32'(maddr_1), 32'h4);
        check("fetch_mwe",   32'(mwe_1), 32'h0);
        idle(1);
        check("fetch_rv",    32'(iv_1), 32'h1);
        check("fetch_rdata", ir_1, mw(30'h4));
        check("fetch_drv",   32'(dv_1), 32'h0);
        check("fetch_drd",   dr_1, 32'h0);
        idle(1);
        check("fetch_rv_pulse", 32'(iv_1), 32'h0);
        check("fetch_rd_zero",  ir_1, 32'h0);
        idle(3);

        // Byte store: no response on either port.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0103, 4'b1000, 32'hAB00_0000);
        check("st_gnt",   32'(dg_1), 32'h1);
        check("st_maddr", 32'(maddr_1), 32'h40);
        check("st_mwe",   32'(mwe_1), 32'h8);
        check("st_mwd",   mwd_1, 32'hAB00_0000);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("st_norv1", 32'({iv_1, dv_1}), 32'h0);
            check("st_norv3", 32'({iv_3, dv_3}), 32'h0);
        end
        idle(2);

        // Contention: data wins 4 cycles, then inst, repeating every 5.
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 4'h0, 32'h0);
            exp_i = ((k % 5) == 4);
            check("cont_ignt",  32'(ig_1), 32'(exp_i));
            check("cont_dgnt",  32'(dg_1), 32'(!exp_i));
            check("cont_maddr", 32'(maddr_1), exp_i ? 32'hC0 : 32'h80);
            if (k > 0) begin
                prev_i = (((k - 1) % 5) == 4);
                check("cont_irv", 32'(iv_1), 32'(prev_i));
                check("cont_drv", 32'(dv_1), 32'(!prev_i));
                check("cont_ird", ir_1, prev_i ? mw(30'hC0) : 32'h0);
                check("cont_drd", dr_1, prev_i ? 32'h0 : mw(30'h80));
            end
        end
        idle(4);

        // Read ordering, latency 3: inst, data, inst.
        cyc(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h24, 4'h0, 32'h0);
        cyc(1'b1, 1'b1, 32'h28, 1'b0, 32'h0, 4'h0, 32'h0);
        idle(1);
        check("ord0_irv", 32'({iv_3, dv_3}), 32'h2);
        check("ord0_ird", ir_3, mw(30'h8));
        idle(1);
        check("ord1_drv", 32'({iv_3, dv_3}), 32'h1);
        check("ord1_drd", dr_3, mw(30'h9));
        check("ord1_ird", ir_3, 32'h0);
        idle(1);
        check("ord2_irv", 32'({iv_3, dv_3}), 32'h2);
        check("ord2_ird", ir_3, mw(30'hA));
        idle(1);
        check("ord3_quiet", 32'({iv_3, dv_3}), 32'h0);
        idle(3);

        // Reset mid-flight, latency 2: in-flight load is discarded.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h30, 4'h0, 32'h0);
        check("rmf_gnt", 32'(dg_2), 32'h1);
        cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'h44, 4'h0, 32'h0);
        check("rmf_gnts", 32'({ig_2, dg_2, ig_1, dg_1}), 32'h0);
        check("rmf_men",  32'({men_2, men_1}), 32'h0);
        check("rmf_maddr", 32'(maddr_2), 32'h0);
        check("rmf_rv",   32'({iv_2, dv_2, iv_1, dv_1}), 32'h0);
        check("rmf_rd",   dr_1 | ir_1 | dr_2 | ir_2, 32'h0);
        idle(1);
        check("rmf_no_rv", 32'({iv_2, dv_2}), 32'h0);
        check("rmf_no_rd", dr_2, 32'h0);
        idle(1);
        check("rmf_no_rv2", 32'({iv_2, dv_2, iv_3, dv_3}), 32'h0);
        idle(3);

        // Withdrawal: losing fetch dropped after 2 cycles clears the counter.
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, (k < 2) || (k >= 7), 32'h500, 1'b1, 32'h400, 4'hF, 32'h1122_3344);
            exp_i = (k == 11);
            check("wd_ignt",  32'(ig_1), 32'(exp_i));
            check("wd_dgnt",  32'(dg_1), 32'(!exp_i));
            check("wd_maddr", 32'(maddr_1), exp_i ? 32'h140 : 32'h100);
            check("wd_mwe",   32'(mwe_1), exp_i ? 32'h0 : 32'hF);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
